// File: rtl/sync_shfifo_ext.sv
// Synchronous show-ahead FIFO with arbitrary depth, optional overwrite-oldest overflow,
// runtime almost-empty/almost-full thresholds, level-peak watermark and sticky error flags.
module sync_shfifo_ext #(
    parameter int FIFO_WIDTH = 32,
    parameter int FIFO_DEPTH = 6,
    parameter int OVF_MODE   = 0,
    parameter int PTR_W      = $clog2(FIFO_DEPTH),
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_wen,
    input  logic [FIFO_WIDTH-1:0] fifo_wdat,
    input  logic                  fifo_ren,
    input  logic [CNT_W-1:0]      ae_thr,
    input  logic [CNT_W-1:0]      af_thr,
    input  logic                  err_clr,
    input  logic                  peak_clr,
    output logic [FIFO_WIDTH-1:0] fifo_rdat,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  fifo_aempty,
    output logic                  fifo_afull,
    output logic [CNT_W-1:0]      fifo_rcnt,
    output logic [CNT_W-1:0]      fifo_wcnt,
    output logic [CNT_W-1:0]      fifo_peak,
    output logic                  fifo_ovf_drop,
    output logic                  fifo_wr_full_err,
    output logic                  fifo_rd_empty_err
);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic             OVW_EN   = (OVF_MODE != 0);

    logic [FIFO_WIDTH-1:0] r_mem [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_level;
    logic [CNT_W-1:0]      r_peak;
    logic                  r_ovf_drop;
    logic                  r_wr_err;
    logic                  r_rd_err;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic                  w_ovw;
    logic                  w_wr_err_set;
    logic                  w_rd_err_set;
    logic                  w_rd_adv;
    logic [CNT_W-1:0]      w_next_level;
    logic [CNT_W-1:0]      w_next_peak;

    // Wrap at FIFO_DEPTH-1 explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_max(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == DEPTH_C);

    always_comb begin
        w_rd_ok      = fifo_ren & ~w_empty;
        w_ovw        = 1'b0;
        w_wr_err_set = 1'b0;
        w_wr_ok      = fifo_wen;
        if (w_full && fifo_wen && !fifo_ren) begin
            // Full without a pop: either overwrite the oldest entry or refuse.
            if (OVW_EN) begin
                w_ovw = 1'b1;
            end else begin
                w_wr_ok      = 1'b0;
                w_wr_err_set = 1'b1;
            end
        end
        w_rd_err_set = fifo_ren & w_empty;
        w_rd_adv     = w_rd_ok | w_ovw;

        w_next_level = r_level;
        if (w_wr_ok && !w_rd_ok && !w_ovw) begin
            w_next_level = r_level + CNT_W'(1);
        end else if (w_rd_ok && !w_wr_ok) begin
            w_next_level = r_level - CNT_W'(1);
        end

        w_next_peak = peak_clr ? w_next_level : cnt_max(r_peak, w_next_level);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_peak     <= '0;
            r_ovf_drop <= 1'b0;
            r_wr_err   <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_mem[r_wr_ptr] <= fifo_wdat;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_rd_adv) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_level    <= w_next_level;
            r_peak     <= w_next_peak;
            r_ovf_drop <= w_ovw;
            // A new error in the same cycle as err_clr must survive the clear.
            r_wr_err   <= w_wr_err_set | (r_wr_err & ~err_clr);
            r_rd_err   <= w_rd_err_set | (r_rd_err & ~err_clr);
        end
    end

    assign fifo_rdat         = r_mem[r_rd_ptr];
    assign fifo_empty        = w_empty;
    assign fifo_full         = w_full;
    assign fifo_aempty       = (r_level <= ae_thr);
    assign fifo_afull        = (r_level >= af_thr);
    assign fifo_rcnt         = r_level;
    assign fifo_wcnt         = DEPTH_C - r_level;
    assign fifo_peak         = r_peak;
    assign fifo_ovf_drop     = r_ovf_drop;
    assign fifo_wr_full_err  = r_wr_err;
    assign fifo_rd_empty_err = r_rd_err;

endmodule

// File: tb/tb_sync_shfifo_ext.sv
// Bench for sync_shfifo_ext: a blocking-mode and an overwrite-mode instance share one
// stimulus stream and are compared against a queue-based reference model every cycle.
module tb_sync_shfifo_ext;

    localparam int W  = 32;
    localparam int D  = 6;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst, wen, ren, err_clr, peak_clr;
    logic [W-1:0]  wdat;
    logic [CW-1:0] ae_thr, af_thr;

    logic [W-1:0]  rdat  [2];
    logic          empty [2];
    logic          full  [2];
    logic          aempty[2];
    logic          afull [2];
    logic [CW-1:0] rcnt  [2];
    logic [CW-1:0] wcnt  [2];
    logic [CW-1:0] peak  [2];
    logic          drop  [2];
    logic          werr  [2];
    logic          rerr  [2];

    logic [W-1:0]  mq [2][$];
    int            mpeak [2];
    bit            mdrop [2];
    bit            mwerr [2];
    bit            mrerr [2];

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    sync_shfifo_ext #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .OVF_MODE(0)) u_blk (
        .clk(clk), .rst(rst), .fifo_wen(wen), .fifo_wdat(wdat), .fifo_ren(ren),
        .ae_thr(ae_thr), .af_thr(af_thr), .err_clr(err_clr), .peak_clr(peak_clr),
        .fifo_rdat(rdat[0]), .fifo_empty(empty[0]), .fifo_full(full[0]),
        .fifo_aempty(aempty[0]), .fifo_afull(afull[0]), .fifo_rcnt(rcnt[0]),
        .fifo_wcnt(wcnt[0]), .fifo_peak(peak[0]), .fifo_ovf_drop(drop[0]),
        .fifo_wr_full_err(werr[0]), .fifo_rd_empty_err(rerr[0])
    );

    sync_shfifo_ext #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .OVF_MODE(1)) u_ovw (
        .clk(clk), .rst(rst), .fifo_wen(wen), .fifo_wdat(wdat), .fifo_ren(ren),
        .ae_thr(ae_thr), .af_thr(af_thr), .err_clr(err_clr), .peak_clr(peak_clr),
        .fifo_rdat(rdat[1]), .fifo_empty(empty[1]), .fifo_full(full[1]),
        .fifo_aempty(aempty[1]), .fifo_afull(afull[1]), .fifo_rcnt(rcnt[1]),
        .fifo_wcnt(wcnt[1]), .fifo_peak(peak[1]), .fifo_ovf_drop(drop[1]),
        .fifo_wr_full_err(werr[1]), .fifo_rd_empty_err(rerr[1])
    );

    task automatic chk(input string tag, input int m, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s[mode%0d] observed=%0h expected=%0h", tag, m, obs, exp);
        end
    endtask

    // Reference behaviour: entries held in a queue, head at index 0.
    task automatic model_edge(input bit r, input bit w, input bit rd, input bit ec,
                              input bit pc, input logic [W-1:0] d);
        for (int m = 0; m < 2; m++) begin
            if (r) begin
                mq[m].delete();
                mpeak[m] = 0;
                mdrop[m] = 0;
                mwerr[m] = 0;
                mrerr[m] = 0;
            end else begin
                int  n    = mq[m].size();
                bit  isf  = (n == D);
                bit  ise  = (n == 0);
                bit  ovw  = 0;
                bit  wset = 0;
                if (isf && w && !rd) begin
                    if (m == 1) begin
                        mq[m].delete(0);
                        mq[m].push_back(d);
                        ovw = 1;
                    end else begin
                        wset = 1;
                    end
                end else begin
                    if (rd && !ise) mq[m].delete(0);
                    if (w) mq[m].push_back(d);
                end
                mdrop[m] = ovw;
                mwerr[m] = wset | (mwerr[m] & !ec);
                mrerr[m] = (rd && ise) | (mrerr[m] & !ec);
                n = mq[m].size();
                mpeak[m] = pc ? n : ((n > mpeak[m]) ? n : mpeak[m]);
            end
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            int n = mq[m].size();
            chk("rcnt",   m, 64'(rcnt[m]),   64'(n));
            chk("wcnt",   m, 64'(wcnt[m]),   64'(D - n));
            chk("empty",  m, 64'(empty[m]),  64'(n == 0));
            chk("full",   m, 64'(full[m]),   64'(n == D));
            chk("aempty", m, 64'(aempty[m]), 64'(n <= int'(ae_thr)));
            chk("afull",  m, 64'(afull[m]),  64'(n >= int'(af_thr)));
            chk("peak",   m, 64'(peak[m]),   64'(mpeak[m]));
            chk("ovfdrop",m, 64'(drop[m]),   64'(mdrop[m]));
            chk("wrerr",  m, 64'(werr[m]),   64'(mwerr[m]));
            chk("rderr",  m, 64'(rerr[m]),   64'(mrerr[m]));
            if (n > 0) chk("rdat", m, 64'(rdat[m]), 64'(mq[m][0]));
        end
    endtask

    task automatic step(input bit r, input bit w, input bit rd, input bit ec,
                        input bit pc, input logic [W-1:0] d);
        rst = r; wen = w; ren = rd; err_clr = ec; peak_clr = pc; wdat = d;
        @(posedge clk);
        model_edge(r, w, rd, ec, pc, d);
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; ren = 1'b0; err_clr = 1'b0; peak_clr = 1'b0;
        wdat = '0; ae_thr = CW'(2); af_thr = CW'(4);

        // Reset state
        step(1, 0, 0, 0, 0, '0);
        step(1, 0, 0, 0, 0, '0);
        for (int m = 0; m < 2; m++) chk("rst_rdat", m, 64'(rdat[m]), 64'h0);

        // Fill 0xA0..0xA5
        for (int i = 0; i < D; i++) step(0, 1, 0, 0, 0, W'(32'hA0 + i));

        // Overflow while full, then error clearing
        step(0, 1, 0, 0, 0, 32'hB6);
        chk("ovw_head", 1, 64'(rdat[1]), 64'hA1);
        chk("blk_head", 0, 64'(rdat[0]), 64'hA0);
        step(0, 0, 0, 0, 0, '0);
        step(0, 0, 0, 1, 0, '0);
        step(0, 1, 0, 1, 0, 32'hB7);
        step(0, 0, 0, 1, 0, '0);

        // Simultaneous push/pop while full
        step(0, 1, 1, 0, 0, 32'hC0);

        // Drain, then read from empty
        for (int i = 0; i < D; i++) step(0, 0, 1, 0, 0, '0);
        step(0, 0, 1, 0, 0, '0);
        step(0, 0, 0, 1, 0, '0);

        // Empty with push and pop together
        step(0, 1, 1, 0, 0, 32'hD0);
        for (int m = 0; m < 2; m++) chk("emp_wr_rd_dat", m, 64'(rdat[m]), 64'hD0);
        step(0, 0, 1, 1, 0, '0);

        // Threshold flags across a full fill; af_thr change takes effect immediately
        ae_thr = CW'(2); af_thr = CW'(4);
        for (int i = 0; i < D; i++) begin
            step(0, 1, 0, 0, 0, W'(32'h10 + i));
            if (i == 4) begin
                af_thr = CW'(6);
                #1;
                for (int m = 0; m < 2; m++) chk("afull_live", m, 64'(afull[m]), 64'h0);
            end
        end
        for (int i = 0; i < D; i++) step(0, 0, 1, 0, 0, '0);

        // Mid-stream reset with errors and contents present
        step(0, 0, 1, 0, 0, '0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, W'(32'h30 + i));
        step(1, 1, 0, 0, 0, 32'hEE);
        for (int m = 0; m < 2; m++) chk("midrst_rdat", m, 64'(rdat[m]), 64'h0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            bit r  = ($urandom_range(0, 99) == 0);
            bit w  = ($urandom_range(0, 99) < ((i % 200) < 100 ? 70 : 35));
            bit rd = ($urandom_range(0, 99) < ((i % 200) < 100 ? 35 : 70));
            bit ec = ($urandom_range(0, 15) == 0);
            bit pc = ($urandom_range(0, 15) == 0);
            ae_thr = CW'($urandom_range(0, D));
            af_thr = CW'($urandom_range(0, D));
            step(r, w, rd, ec, pc, W'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
